// File: rtl/hv_pkg.sv
// Shared types and defaults for the hypervector bundler.
package hv_pkg;

  localparam int HV_DIM   = 1023;
  localparam int HV_CNT_W = 8;

  typedef logic [HV_DIM:0] hv_t;

  typedef enum logic [2:0] {
    IDLE,
    ACC,
    RESOLVE,
    HOLD,
    DONE
  } bundler_state_e;

endpackage

// File: rtl/hv_bit_counter.sv
// One bit lane of the bundler: counts ones seen on this bit and votes majority.
module hv_bit_counter
  import hv_pkg::*;
#(
  parameter int CNT_W = HV_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc_en,
  input  logic             bit_in,
  input  logic [CNT_W-1:0] n,
  input  logic             tie,
  output logic             maj
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   twice;
  logic [CNT_W:0]   n_ext;

  // Ones counter; it only moves on accepted vectors, so it can never exceed n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc_en && bit_in) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Majority with the tie broken by the first vector of the bundle.
  always_comb begin
    twice = {cnt, 1'b0};
    n_ext = {1'b0, n};
    maj   = (twice > n_ext) | ((twice == n_ext) & tie);
  end

endmodule

// File: rtl/hv_bundler.sv
// Majority bundler: accumulates stored hypervectors and emits one bundled HV per job.
module hv_bundler
  import hv_pkg::*;
#(
  parameter int DIM   = HV_DIM,
  parameter int CNT_W = HV_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             store,
  input  logic             last,
  input  logic [DIM:0]     core_result,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [DIM:0]     out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] N_MAX = '1;

  bundler_state_e   state;
  logic [CNT_W-1:0] n;
  logic [DIM:0]     tie_vec;
  logic [DIM:0]     data_q;
  logic [DIM:0]     maj_vec;
  logic             store_q;
  logic             last_q;
  logic             accept;
  logic             drop;

  assign accept = (state == ACC) && store_q && (n != N_MAX);
  assign drop   = (state == ACC) && store_q && (n == N_MAX);

  // Input stage: registers the upstream vector so the wide counter fan-out starts from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      store_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
    end else if (!run) begin
      store_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      store_q <= store;
      last_q  <= store & last;
      data_q  <= core_result;
    end
  end

  genvar i;
  generate
    for (i = 0; i <= DIM; i++) begin : g_lane
      hv_bit_counter #(
        .CNT_W (CNT_W)
      ) u_lane (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (!run),
        .inc_en (accept),
        .bit_in (data_q[i]),
        .n      (n),
        .tie    (tie_vec[i]),
        .maj    (maj_vec[i])
      );
    end
  endgenerate

  // Job sequencing, vector count, overflow flag, tie vector and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      n         <= '0;
      ovf       <= 1'b0;
      tie_vec   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
    end else if (!run) begin
      state     <= IDLE;
      n         <= '0;
      ovf       <= 1'b0;
      tie_vec   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          state <= ACC;
        end
        ACC: begin
          if (accept) begin
            n <= n + CNT_W'(1);
            if (n == '0) begin
              tie_vec <= data_q;
            end
          end
          if (drop) begin
            ovf <= 1'b1;
          end
          if (store_q && last_q) begin
            state <= RESOLVE;
          end
        end
        RESOLVE: begin
          out_data  <= (n == '0) ? '0 : maj_vec;
          out_count <= n;
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= DONE;
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hv_bundler.sv
// Randomized self-checking bench for hv_bundler against a queue-based majority model.
module tb_hv_bundler;
  import hv_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, run, store, last, out_ready;
  logic [1023:0] core_result;
  logic          out_valid, ovf;
  logic [1023:0] out_data;
  logic [7:0]    out_count;

  logic          s_run, s_store, s_last, s_ready;
  logic [15:0]   s_core;
  logic          s_valid, s_ovf;
  logic [15:0]   s_data;
  logic [1:0]    s_count;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [1023:0] acc_q[$];
  bit            model_ovf;

  hv_bundler #(.DIM(1023), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .store(store), .last(last),
    .core_result(core_result), .out_ready(out_ready), .out_valid(out_valid),
    .out_data(out_data), .out_count(out_count), .ovf(ovf)
  );

  hv_bundler #(.DIM(15), .CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .run(s_run), .store(s_store), .last(s_last),
    .core_result(s_core), .out_ready(s_ready), .out_valid(s_valid),
    .out_data(s_data), .out_count(s_count), .ovf(s_ovf)
  );

  // Reference: bundle = per-bit vote over the accepted vectors, first vector breaks ties.
  function automatic logic [1023:0] model_bundle();
    logic [1023:0] r;
    int nv;
    r  = '0;
    nv = acc_q.size();
    for (int b = 0; b < 1024; b++) begin
      int ones;
      ones = 0;
      foreach (acc_q[j]) ones += int'(acc_q[j][b]);
      if (nv != 0) begin
        if (2 * ones > nv) r[b] = 1'b1;
        else if (2 * ones == nv) r[b] = acc_q[0][b];
      end
    end
    return r;
  endfunction

  function automatic void model_push(input logic [1023:0] v, input int maxn);
    if (acc_q.size() < maxn) acc_q.push_back(v);
    else model_ovf = 1'b1;
  endfunction

  function automatic logic [1023:0] rand_vec();
    logic [1023:0] r;
    for (int w = 0; w < 32; w++) r[w*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic big_start();
    @(negedge clk);
    run = 1'b1; store = 1'b0; last = 1'b0; core_result = '0; out_ready = 1'b0;
    acc_q.delete();
    model_ovf = 1'b0;
    @(negedge clk);
  endtask

  task automatic big_store(input logic [1023:0] v, input logic is_last);
    core_result = v; store = 1'b1; last = is_last;
    model_push(v, 255);
    @(negedge clk);
  endtask

  task automatic big_quiet();
    store = 1'b0; last = 1'b0; core_result = '0;
  endtask

  task automatic big_end();
    run = 1'b0; store = 1'b0; last = 1'b0; core_result = '0; out_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_big(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; run = 1'b0; store = 1'b0; last = 1'b0; core_result = '0; out_ready = 1'b0;
    s_run = 1'b0; s_store = 1'b0; s_last = 1'b0; s_core = '0; s_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_valid got %b want 0", out_valid); end
    n_cmp++; if (out_data !== '0) begin n_fail++; $display("[TB] FAIL reset_data got %h want 0", out_data[63:0]); end
    n_cmp++; if (out_count !== 8'd0) begin n_fail++; $display("[TB] FAIL reset_count got %0d want 0", out_count); end
    n_cmp++; if (ovf !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ovf got %b want 0", ovf); end
    n_cmp++; if (s_valid !== 1'b0 || s_ovf !== 1'b0 || s_count !== 2'd0 || s_data !== 16'h0) begin
      n_fail++; $display("[TB] FAIL reset_small got v=%b o=%b c=%0d d=%h want all 0", s_valid, s_ovf, s_count, s_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_majority();
    logic [1023:0] aa;
    aa = {256{4'hA}};
    big_start();
    big_store('1, 1'b0);
    big_store('0, 1'b0);
    big_store(aa, 1'b1);
    big_quiet();
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL maj_lat_k got %b want 0", out_valid); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL maj_lat_k1 got %b want 0", out_valid); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL maj_lat_k2 got %b want 1", out_valid); end
    n_cmp++; if (out_data !== model_bundle()) begin
      n_fail++; $display("[TB] FAIL maj_data got %h want %h", out_data[63:0], aa[63:0]);
    end
    n_cmp++; if (out_count !== 8'd3) begin n_fail++; $display("[TB] FAIL maj_count got %0d want 3", out_count); end
    n_cmp++; if (ovf !== 1'b0) begin n_fail++; $display("[TB] FAIL maj_ovf got %b want 0", ovf); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL maj_handshake got %b want 0", out_valid); end
    big_end();
  endtask

  task automatic test_tie();
    logic [1023:0] a;
    int cyc;
    a = {128{8'h5A}};
    big_start();
    big_store(a, 1'b0);
    big_store(~a, 1'b1);
    big_quiet();
    wait_big(cyc);
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL tie_timeout got %b want 1", out_valid); end
    n_cmp++; if (out_data !== a) begin n_fail++; $display("[TB] FAIL tie_data got %h want %h", out_data[63:0], a[63:0]); end
    n_cmp++; if (out_count !== 8'd2) begin n_fail++; $display("[TB] FAIL tie_count got %0d want 2", out_count); end
    out_ready = 1'b1;
    @(negedge clk);
    big_end();
  endtask

  task automatic test_backpressure();
    logic [1023:0] exp_data;
    int cyc;
    big_start();
    big_store(rand_vec(), 1'b0);
    big_store(rand_vec(), 1'b0);
    big_store(rand_vec(), 1'b1);
    big_quiet();
    exp_data = model_bundle();
    wait_big(cyc);
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_timeout got %b want 1", out_valid); end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b1 || out_data !== exp_data || out_count !== 8'd3) begin
        n_fail++; $display("[TB] FAIL bp_stable cycle %0d got v=%b c=%0d d=%h want v=1 c=3 d=%h",
                           c, out_valid, out_count, out_data[63:0], exp_data[63:0]);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_release got %b want 0", out_valid); end
    n_cmp++; if (dut.state !== DONE) begin n_fail++; $display("[TB] FAIL bp_state got %0d want %0d", dut.state, DONE); end
    big_end();
  endtask

  task automatic test_abort();
    logic [1023:0] v;
    int cyc;
    v = {128{8'h0F}};
    big_start();
    big_store(rand_vec(), 1'b0);
    big_store(rand_vec(), 1'b0);
    run = 1'b0; store = 1'b0; core_result = '0;
    acc_q.delete();
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    big_store(v, 1'b1);
    big_quiet();
    wait_big(cyc);
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL abort_timeout got %b want 1", out_valid); end
    n_cmp++; if (out_data !== v) begin n_fail++; $display("[TB] FAIL abort_data got %h want %h", out_data[63:0], v[63:0]); end
    n_cmp++; if (out_count !== 8'd1) begin n_fail++; $display("[TB] FAIL abort_count got %0d want 1", out_count); end
    out_ready = 1'b1;
    @(negedge clk);
    big_end();
  endtask

  task automatic small_job(input int nv, input bit fixed, input string tag);
    logic [15:0] v;
    logic [1023:0] exp_full;
    int cyc;
    @(negedge clk);
    s_run = 1'b1; s_store = 1'b0; s_last = 1'b0; s_core = '0; s_ready = 1'b0;
    acc_q.delete();
    model_ovf = 1'b0;
    @(negedge clk);
    for (int k = 0; k < nv; k++) begin
      if (fixed) v = (k < nv - 1) ? 16'hFFFF : 16'h0000;
      else v = 16'($urandom);
      s_core = v; s_store = 1'b1; s_last = (k == nv - 1);
      model_push({1008'b0, v}, 3);
      @(negedge clk);
    end
    s_store = 1'b0; s_last = 1'b0; s_core = '0;
    exp_full = model_bundle();
    cyc = 0;
    while (!s_valid && cyc < 40) begin @(negedge clk); cyc++; end
    n_cmp++; if (s_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL %s_timeout got %b want 1", tag, s_valid); end
    n_cmp++; if (s_data !== exp_full[15:0]) begin n_fail++; $display("[TB] FAIL %s_data got %h want %h", tag, s_data, exp_full[15:0]); end
    n_cmp++; if (int'(s_count) != acc_q.size()) begin n_fail++; $display("[TB] FAIL %s_count got %0d want %0d", tag, s_count, acc_q.size()); end
    n_cmp++; if (s_ovf !== model_ovf) begin n_fail++; $display("[TB] FAIL %s_ovf got %b want %b", tag, s_ovf, model_ovf); end
    s_ready = 1'b1;
    @(negedge clk);
    s_run = 1'b0; s_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_overflow();
    small_job(5, 1'b1, "ovf_fixed");
    n_cmp++; if (model_ovf !== 1'b1 || acc_q.size() != 3) begin
      n_fail++; $display("[TB] FAIL ovf_model got ovf=%b n=%0d want ovf=1 n=3", model_ovf, acc_q.size());
    end
    for (int j = 0; j < 4; j++) small_job(int'($urandom_range(1, 6)), 1'b0, "ovf_rand");
  endtask

  task automatic test_random();
    logic [1023:0] exp_data;
    int nv, cyc, hold;
    for (int j = 0; j < 6; j++) begin
      big_start();
      nv = int'($urandom_range(1, 12));
      for (int k = 0; k < nv; k++) begin
        big_store(rand_vec(), k == nv - 1);
        if ($urandom_range(0, 2) == 0 && k != nv - 1) begin
          big_quiet();
          repeat ($urandom_range(1, 3)) @(negedge clk);
        end
      end
      big_quiet();
      exp_data = model_bundle();
      wait_big(cyc);
      n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL rand_timeout job %0d got %b want 1", j, out_valid); end
      n_cmp++; if (out_data !== exp_data) begin n_fail++; $display("[TB] FAIL rand_data job %0d got %h want %h", j, out_data[63:0], exp_data[63:0]); end
      n_cmp++; if (int'(out_count) != nv) begin n_fail++; $display("[TB] FAIL rand_count job %0d got %0d want %0d", j, out_count, nv); end
      n_cmp++; if (ovf !== model_ovf) begin n_fail++; $display("[TB] FAIL rand_ovf job %0d got %b want %b", j, ovf, model_ovf); end
      hold = int'($urandom_range(0, 3));
      repeat (hold) @(negedge clk);
      n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL rand_hold job %0d got %b want 1", j, out_valid); end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rand_release job %0d got %b want 0", j, out_valid); end
      big_end();
    end
  endtask

  task automatic test_held_last();
    logic [1023:0] v;
    int cyc;
    big_start();
    big_store(rand_vec(), 1'b0);
    v = rand_vec();
    big_store(v, 1'b1);
    wait_big(cyc);
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL held_timeout got %b want 1", out_valid); end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL held_retrigger cycle %0d got %b want 0", c, out_valid); end
    end
    big_end();
    big_start();
    big_store(rand_vec(), 1'b1);
    big_quiet();
    wait_big(cyc);
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL held2_timeout got %b want 1", out_valid); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL async_reset_valid got %b want 0", out_valid); end
    n_cmp++; if (out_count !== 8'd0) begin n_fail++; $display("[TB] FAIL async_reset_count got %0d want 0", out_count); end
    @(negedge clk);
    run = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_majority();
    test_tie();
    test_backpressure();
    test_abort();
    test_overflow();
    test_random();
    test_held_last();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
